// File: rtl/bcd_pkg.sv
// Shared types, constants and the digit-validity test for the BCD word checker.
// Build option BCD_WORD_CHECKER_CORRECT_EN (see bcd_digit_check) substitutes 9 for bad digits.
package bcd_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    REPORT  = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // A nibble is out of BCD range exactly when it is 10..15.
  function automatic logic bcd_invalid(input logic [3:0] d);
    return d[3] & (d[2] | d[1]);
  endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Per-digit checker: flags a non-BCD nibble and, when BCD_WORD_CHECKER_CORRECT_EN
// is defined, also produces a corrected digit clamped to BCD_MAX.
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic       err
`ifdef BCD_WORD_CHECKER_CORRECT_EN
  ,
  output logic [3:0] fixed
`endif
);

  assign err = bcd_invalid(digit);

`ifdef BCD_WORD_CHECKER_CORRECT_EN
  assign fixed = err ? BCD_MAX : digit;
`endif

endmodule

// File: rtl/bcd_word_checker.sv
// Collects NDIG BCD digits (MSD first) into a word, flags invalid digits and counts
// delivered erroneous words. Build option: BCD_WORD_CHECKER_CORRECT_EN.
module bcd_word_checker
  import bcd_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [3:0]          in_digit,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*NDIG-1:0]   out_word,
  output logic [NDIG-1:0]     out_err_mask,
  output logic                out_err_any,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                sticky_err
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [4*NDIG-1:0] asm_q;
  logic [4*NDIG-1:0] cand_word;
  logic [4*NDIG-1:0] chk_word;
  logic [NDIG-1:0]   cand_mask;
  logic              accept;
  logic              last_digit;
  logic              deliver;

  // The word as it would look with the incoming digit in place, so the final
  // digit can be checked and registered in the same cycle it is accepted.
  always_comb begin
    cand_word = asm_q;
    cand_word[4*(NDIG-1-int'(idx_q)) +: 4] = in_digit;
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_chk
    bcd_digit_check u_chk (
      .digit (cand_word[4*g +: 4]),
      .err   (cand_mask[g])
`ifdef BCD_WORD_CHECKER_CORRECT_EN
      ,
      .fixed (chk_word[4*g +: 4])
`endif
    );
  end

`ifndef BCD_WORD_CHECKER_CORRECT_EN
  assign chk_word = cand_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      COLLECT: in_ready  = 1'b1;
      REPORT:  out_valid = 1'b1;
      default: ;
    endcase
    accept     = in_ready & in_valid;
    last_digit = accept & (idx_q == LAST_IDX);
    deliver    = out_valid & out_ready;
    if (clr)             state_d = COLLECT;
    else if (last_digit) state_d = REPORT;
    else if (deliver)    state_d = COLLECT;
  end

  // clr wins over acceptance and delivery: the digit or word in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      asm_q        <= '0;
      out_word     <= '0;
      out_err_mask <= '0;
      out_err_any  <= 1'b0;
      err_cnt      <= '0;
      sticky_err   <= 1'b0;
    end else if (clr) begin
      idx_q      <= '0;
      asm_q      <= '0;
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else begin
      if (accept) begin
        if (last_digit) begin
          idx_q        <= '0;
          asm_q        <= '0;
          out_word     <= chk_word;
          out_err_mask <= cand_mask;
          out_err_any  <= |cand_mask;
        end else begin
          idx_q <= idx_q + 1'b1;
          asm_q <= cand_word;
        end
      end
      if (deliver && out_err_any) begin
        sticky_err <= 1'b1;
        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_word_checker.sv
// Scoreboard bench for bcd_word_checker (NDIG=4, CNT_W=2); honours BCD_WORD_CHECKER_CORRECT_EN.
module tb_bcd_word_checker;

  localparam int NDIG  = 4;
  localparam int CNT_W = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clr;
  logic                in_valid;
  logic [3:0]          in_digit;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [4*NDIG-1:0]   out_word;
  logic [NDIG-1:0]     out_err_mask;
  logic                out_err_any;
  logic [CNT_W-1:0]    err_cnt;
  logic                sticky_err;

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  mask;
    logic        any;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_word_checker #(.NDIG(NDIG), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_digit     (in_digit),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_err_mask (out_err_mask),
    .out_err_any  (out_err_any),
    .err_cnt      (err_cnt),
    .sticky_err   (sticky_err)
  );

  function automatic logic [3:0] model_mask(input logic [15:0] w);
    logic [3:0] m;
    for (int i = 0; i < NDIG; i++) m[i] = (w[4*i +: 4] > 4'd9);
    return m;
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] w);
    logic [15:0] r;
    r = w;
`ifdef BCD_WORD_CHECKER_CORRECT_EN
    for (int i = 0; i < NDIG; i++) if (w[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word MSD first; the expected delivery goes to the scoreboard.
  task automatic applyStimulus(input logic [15:0] w);
    exp_t e;
    int   waits;
    e.word = model_word(w);
    e.mask = model_mask(w);
    e.any  = |model_mask(w);
    exp_q.push_back(e);
    for (int i = NDIG - 1; i >= 0; i--) begin
      waits = 0;
      while (!in_ready && waits < 50) begin
        step();
        waits++;
      end
      if (waits >= 50) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_digit = w[4*i +: 4];
      step();
    end
    in_valid = 1'b0;
    in_digit = 4'h0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word: got %0h, expected no delivery", out_word);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("out_word", 32'(out_word), 32'(mon_e.word));
        checkOutput("out_err_mask", 32'(out_err_mask), 32'(mon_e.mask));
        checkOutput("out_err_any", 32'(out_err_any), 32'(mon_e.any));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_digit  = 4'h0;
    out_ready = 1'b1;
    repeat (2) step();

    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_word", 32'(out_word), 32'd0);
    checkOutput("rst_mask", 32'(out_err_mask), 32'd0);
    checkOutput("rst_err_any", 32'(out_err_any), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_sticky", 32'(sticky_err), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] clean word");
    applyStimulus(16'h1234);
    step();
    checkOutput("clean_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("clean_sticky", 32'(sticky_err), 32'd0);

    $display("[TB] erroneous word");
    applyStimulus(16'h1A3F);
    step();
    checkOutput("err_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("err_sticky", 32'(sticky_err), 32'd1);

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(16'h2B5C);
    in_valid = 1'b1;
    in_digit = 4'h7;
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_out_word", 32'(out_word), 32'(model_word(16'h2B5C)));
      checkOutput("stall_mask", 32'(out_err_mask), 32'(model_mask(16'h2B5C)));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("release_err_cnt", 32'(err_cnt), 32'd2);
    applyStimulus(16'h0909);
    step();

    $display("[TB] counter saturation");
    clr = 1'b1;
    step();
    clr = 1'b0;
    checkOutput("clr_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("clr_sticky", 32'(sticky_err), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus({4'hE, 4'h0, 4'h0, 4'(k)});
      step();
      checkOutput("sat_err_cnt", 32'(err_cnt), (k > 3) ? 32'd3 : 32'(k));
    end

    $display("[TB] reset mid-word");
    in_valid = 1'b1;
    in_digit = 4'h1;
    step();
    in_digit = 4'h2;
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("midrst_sticky", 32'(sticky_err), 32'd0);
    checkOutput("midrst_out_word", 32'(out_word), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h5678);
    step();
    checkOutput("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("post_rst_sticky", 32'(sticky_err), 32'd0);

    $display("[TB] clr during delivery");
    applyStimulus(16'h00A0);
    step();
    checkOutput("pre_clr_err_cnt", 32'(err_cnt), 32'd1);
    out_ready = 1'b0;
    applyStimulus(16'hB123);
    step();
    out_ready = 1'b1;
    clr       = 1'b1;
    step();
    clr = 1'b0;
    checkOutput("clr_dlv_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("clr_dlv_sticky", 32'(sticky_err), 32'd0);
    checkOutput("clr_dlv_in_ready", 32'(in_ready), 32'd1);
    checkOutput("clr_dlv_out_valid", 32'(out_valid), 32'd0);

    repeat (2) step();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_word_checker.md
BCD_WORD_CHECKER -- requirements
Module: bcd_word_checker

Interface
REQ-001 SHALL have parameter NDIG, default 4: BCD digits per word, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 8: width of the error-word counter, legal range 1..32.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port clr  input  1  synchronous clear of counter, sticky flag and word assembly.
REQ-006 SHALL have port in_valid  input  1  in_digit carries a digit this cycle.
REQ-007 SHALL have port in_digit  input  4  one BCD digit, most significant digit of a word first.
REQ-008 SHALL have port in_ready  output  1  block accepts a digit this cycle.
REQ-009 SHALL have port out_valid  output  1  a completed word is presented.
REQ-010 SHALL have port out_ready  input  1  consumer takes the presented word.
REQ-011 SHALL have port out_word  output  4*NDIG  assembled word; digit i occupies bits [4i+3:4i].
REQ-012 SHALL have port out_err_mask  output  NDIG  bit i set when digit i is not valid BCD.
REQ-013 SHALL have port out_err_any  output  1  OR of out_err_mask.
REQ-014 SHALL have port err_cnt  output  CNT_W  count of delivered words with out_err_any=1.
REQ-015 SHALL have port sticky_err  output  1  set by any delivered erroneous word; held until clr or reset.

Function
REQ-016 SHALL implement a two-state FSM: COLLECT (in_ready=1, out_valid=0) and REPORT (in_ready=0, out_valid=1).
REQ-017 SHALL accept a digit in COLLECT when in_valid=1; the first accepted digit lands in digit NDIG-1, the last in digit 0.
REQ-018 SHALL, on acceptance of the NDIG-th digit, enter REPORT on the next cycle with out_word, out_err_mask and out_err_any registered and stable.
REQ-019 SHALL flag a digit as invalid when d[3] & (d[2] | d[1]), i.e. values 10..15.
REQ-020 SHALL hold all outputs stable in REPORT while out_ready=0.
REQ-021 SHALL return to COLLECT on the cycle after out_valid & out_ready; that handshake is the delivery event.
REQ-022 SHALL NOT accept a digit in REPORT, even if out_ready=1 in the same cycle; there is no bypass path.
REQ-023 SHALL, on delivery of a word with out_err_any=1, increment err_cnt by one, saturating at 2^CNT_W-1, and set sticky_err.
REQ-024 SHALL, on clr=1, zero err_cnt, sticky_err and the digit index, discard any partial or pending word, and enter COLLECT.
REQ-025 SHALL give clr priority over simultaneous digit acceptance and delivery; that digit or word is dropped and not counted.
REQ-026 SHALL ignore in_digit whenever in_valid=0.

Reset
REQ-027 SHALL, while rst_n=0, force FSM=COLLECT, digit index=0, out_word=0, out_err_mask=0, out_err_any=0, err_cnt=0, sticky_err=0, out_valid=0.
REQ-028 SHALL drop any partial word on reset asserted mid-word; the first digit after release starts a new word.
REQ-029 SHALL accept a digit on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL support macro BCD_WORD_CHECKER_CORRECT_EN.
REQ-031 SHALL, when the macro is defined, replace each invalid digit in out_word with 4'h9, leaving out_err_mask unchanged.
REQ-032 SHALL, when the macro is undefined, pass raw digits through to out_word.

Structure
REQ-033 SHALL place the FSM state type, constant BCD_MAX=4'd9 and the digit-validity function in shared package bcd_pkg.
REQ-034 SHALL instantiate NDIG copies of sub-module bcd_digit_check: 4-bit digit in, error bit and, under the macro, corrected digit out.

Verification (NDIG=4 unless stated)
REQ-035 SHALL test: digits 1,2,3,4 -> out_word=16'h1234, mask=4'b0000, err_cnt=0.
REQ-036 SHALL test: digits 1,A,3,F without macro -> out_word=16'h1A3F, mask=4'b0101, err_cnt=1, sticky_err=1; with macro -> out_word=16'h1939.
REQ-037 SHALL test: out_ready held 0 for 5 cycles in REPORT with in_valid=1 -> outputs stable, in_ready=0, no digit accepted; release -> COLLECT next cycle.
REQ-038 SHALL test: CNT_W=2, five erroneous words -> err_cnt=3 after the third and later words.
REQ-039 SHALL test: rst_n pulsed low after 2 digits, then digits 5,6,7,8 -> out_word=16'h5678, counters=0.
REQ-040 SHALL test: clr asserted in the same cycle as delivery of an erroneous word -> err_cnt=0, sticky_err=0, FSM=COLLECT.
